usb_prod_sched: RTL and testbench
=================================

# usb_prod_sched

Burst scheduler for the USB test-pattern path. It sequences a dummy counter producer into the USB transmit FIFO as a programmable train of bursts: N words per burst, G idle cycles between bursts, B bursts total or free-running. It drives the producer's reset and enable, and honours FIFO almost-full backpressure. It reports progress and completion to the control/status registers.

## Interface
- `LEN_W`, 16: width of burst length.
- `GAP_W`, 16: width of inter-burst gap.
- `CNT_W`, 16: width of burst count and burst progress.
- `WRD_W`, 32: width of accepted-word counter.
- `TO_W`, 12: watchdog width (used only with `USB_SCHED_WDOG_EN`).

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: synchronous, active-low reset.
- `start_i` in 1: start a run. Sampled only in IDLE.
- `abort_i` in 1: stop the run after the current cycle.
- `burst_len_i` in LEN_W: words per burst. Latched at start.
- `gap_len_i` in GAP_W: idle cycles between bursts. Latched at start.
- `burst_num_i` in CNT_W: number of bursts. Latched at start; 0 = run until abort.
- `fifo_almst_full_i` in 1: FIFO backpressure.
- `prod_wr_i` in 1: producer's registered FIFO write strobe.
- `prod_rst_o` out 1: active-high producer reset.
- `prod_en_o` out 1: producer enable.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse at run end.
- `timeout_o` out 1: sticky watchdog flag.
- `bursts_done_o` out CNT_W: bursts completed.
- `words_o` out WRD_W: `prod_wr_i` strobes counted this run.

## Operation
- States: IDLE, PRST, BURST, GAP, DRAIN, DONE; ERR exists only with the watchdog.
- IDLE → PRST on `start_i`=1 with `burst_len_i`≠0. In that same edge:
  - latch the configuration;
  - clear `bursts_done_o`, `words_o`, `timeout_o`.
- `start_i` is ignored when `burst_len_i`=0 or when not in IDLE.
- PRST lasts one cycle, with `prod_rst_o`=1. Then → BURST.
- Issue condition: issue = `prod_en_o` & !`fifo_almst_full_i`.
- BURST:
  - `prod_en_o`=1;
  - an internal issue counter increments on each issue;
  - on the issue that makes the count equal `burst_len`: clear the issue counter, increment `bursts_done_o`, and `prod_en_o` falls at that edge.
  - Exactly `burst_len` issues occur per burst.
- Leaving BURST after the last issue:
  - `burst_num`≠0 and `bursts_done_o`+1 = `burst_num` → DRAIN;
  - else `gap_len`=0 → stay in BURST (back-to-back; `prod_en_o` stays 1);
  - else → GAP.
- GAP: `prod_en_o`=0 for exactly `gap_len` cycles, then → BURST.
- DRAIN: one cycle, so the final registered `prod_wr_i` is counted. Then → DONE.
- DONE: `done_o`=1 for one cycle, then → IDLE.
- `abort_i` in PRST, BURST or GAP → DRAIN.
  - `prod_en_o`=0 from the next cycle.
  - `bursts_done_o` counts only completed bursts.
  - Abort beats a simultaneous last issue: the burst still counts, and the next state is DRAIN.
- `words_o` increments on every `prod_wr_i` while `busy_o`=1. It saturates at all-ones.
- `bursts_done_o` wraps modulo 2^CNT_W. It wraps only in free-run mode.
- Reset (`rst_ni`=0) at any time, including mid-burst:
  - state → IDLE;
  - all outputs 0: `prod_rst_o`, `prod_en_o`, `busy_o`, `done_o`, `timeout_o`, `bursts_done_o`, `words_o`;
  - internal counters cleared.

## Timing
- All outputs are registered.
- `start_i` high at edge k:
  - `prod_rst_o`=1 in cycle k+1;
  - `prod_en_o`=1 from cycle k+2;
  - first `prod_wr_i` (producer-registered) in cycle k+3.
- `fifo_almst_full_i` applies in the same cycle: a cycle with it high is not an issue. It must not drop `prod_en_o`.
- Gap: the last issue edge is followed by `gap_len` cycles with `prod_en_o`=0, then `prod_en_o`=1.
- Last issue at edge j, end of run:
  - DRAIN in cycle j+1;
  - `done_o` in cycle j+2;
  - IDLE from j+3, so `start_i` is accepted at edge j+3.

## Configuration
- `USB_SCHED_WDOG_EN` defined: stall watchdog.
  - In BURST, a TO_W-bit counter increments on each cycle with `prod_en_o`=1 and no issue. It clears on any issue.
  - Reaching 2^TO_W−1 → ERR: `prod_en_o`=0, `timeout_o`=1.
  - ERR holds until `abort_i` → IDLE. No `done_o` pulse.
  - `timeout_o` clears at the next start or on reset.
- Macro undefined: no watchdog, no ERR state.
  - `timeout_o` is tied 0.
  - A stall waits indefinitely.

## Test plan
- Burst train: len=4, gap=3, num=2, no backpressure.
  - Required: 4 issues; `prod_en_o` low for 3 cycles; 4 issues.
  - `done_o` 2 cycles after the last issue; `words_o`=8; `bursts_done_o`=2.
- Backpressure: len=5, gap=0, num=1, `fifo_almst_full_i` high for cycles 2–4 of the burst.
  - Required: exactly 5 issues, with no issue on the stalled cycles; `words_o`=5.
- Free-run with abort: num=0, len=3, gap=1; `abort_i` mid-second-burst after 1 issue.
  - Required: `bursts_done_o`=1; `prod_en_o`=0 next cycle; `done_o` pulses; `words_o`=4.
- Guards: `start_i` with len=0 → stays IDLE. `start_i` while busy → ignored, config unchanged.
- Reset: `rst_ni` low during GAP → IDLE next cycle, all outputs 0. A subsequent start behaves normally.
- With `USB_SCHED_WDOG_EN`, TO_W=4: hold `fifo_almst_full_i` high in BURST.
  - Required: ERR and `timeout_o`=1 after 15 stalled cycles; no `done_o`.
  - `abort_i` → IDLE with `timeout_o` still 1.

Source files
------------

// File: rtl/usb_prod_sched.sv
// usb_prod_sched
//   Burst scheduler for the USB test-pattern path. It drives a dummy counter
//   producer into the USB transmit FIFO as a train of bursts. Each burst is
//   burst_len words. There are gap_len idle cycles between bursts. The run is
//   burst_num bursts long, or free-running when burst_num is 0. FIFO
//   almost-full backpressure is honoured.
//
//   Handshake: a word is issued in any cycle where prod_en_o=1 and
//   fifo_almst_full_i=0. The producer answers each issue with a registered
//   prod_wr_i strobe one cycle later. While prod_en_o stays high the producer
//   may be stalled for any number of cycles.
//
//   Optional feature: define USB_SCHED_WDOG_EN to add a stall watchdog and an
//   ERR state. When it is undefined, timeout_o is tied low.
//
// Ports
//   clk_i, rst_ni       clock, synchronous active-low reset
//   start_i             start a run; sampled only in IDLE and only when
//                       burst_len_i != 0
//   abort_i             end the run through DRAIN (or leave ERR)
//   burst_len_i         words per burst; latched at start
//   gap_len_i           idle cycles between bursts; latched at start
//   burst_num_i         bursts per run; latched at start; 0 = free-run
//   fifo_almst_full_i   FIFO backpressure; a cycle with it high is not an issue
//   prod_wr_i           producer's registered FIFO write strobe
//   prod_rst_o          active-high producer reset (PRST cycle)
//   prod_en_o           producer enable (BURST state)
//   busy_o              high in every state except IDLE
//   done_o              one-cycle pulse at run end
//   timeout_o           sticky watchdog flag
//   bursts_done_o       completed bursts this run
//   words_o             prod_wr_i strobes counted this run (saturating)
//   Internal state register state_q is visible hierarchically for debug.
module usb_prod_sched #(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned GAP_W = 16,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WRD_W = 32,
  parameter int unsigned TO_W  = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [GAP_W-1:0] gap_len_i,
  input  logic [CNT_W-1:0] burst_num_i,
  input  logic             fifo_almst_full_i,
  input  logic             prod_wr_i,
  output logic             prod_rst_o,
  output logic             prod_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] bursts_done_o,
  output logic [WRD_W-1:0] words_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_BURST,
    S_GAP,
    S_DRAIN,
    S_DONE
`ifdef USB_SCHED_WDOG_EN
    , S_ERR
`endif
  } state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0] len_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] num_q;
  logic [LEN_W-1:0] iss_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [CNT_W-1:0] bursts_q;
  logic [WRD_W-1:0] words_q;
  logic             prod_rst_q;
  logic             prod_en_q;
  logic             busy_q;
  logic             done_q;

  logic [LEN_W-1:0] iss_inc;
  logic [GAP_W-1:0] gap_inc;
  logic [CNT_W-1:0] bursts_inc;
  logic             start_ok;
  logic             issue;
  logic             last_issue;
  logic             final_burst;

  assign start_ok   = start_i && (burst_len_i != '0);
  // prod_en_q is high exactly while in BURST, so this is the issue strobe.
  assign issue      = prod_en_q && !fifo_almst_full_i;
  assign iss_inc    = iss_q + LEN_W'(1);
  assign gap_inc    = gap_cnt_q + GAP_W'(1);
  assign bursts_inc = bursts_q + CNT_W'(1);
  assign last_issue = (state_q == S_BURST) && issue && (iss_inc == len_q);
  assign final_burst = (num_q != '0) && (bursts_inc == num_q);

`ifdef USB_SCHED_WDOG_EN
  logic [TO_W-1:0] wd_q;
  logic [TO_W-1:0] wd_inc;
  logic            stall;
  logic            timeout_q;

  assign wd_inc = wd_q + TO_W'(1);
  assign stall  = prod_en_q && fifo_almst_full_i;
`endif

  // Next-state logic. Abort has priority over every other transition,
  // including a simultaneous last issue (whose burst is still counted below).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_PRST;
      end
      S_PRST: begin
        state_d = abort_i ? S_DRAIN : S_BURST;
      end
      S_BURST: begin
        if (abort_i) begin
          state_d = S_DRAIN;
        end else if (last_issue) begin
          if (final_burst)       state_d = S_DRAIN;
          else if (gap_q == '0)  state_d = S_BURST;
          else                   state_d = S_GAP;
        end
`ifdef USB_SCHED_WDOG_EN
        else if (stall && (wd_inc == '1)) begin
          state_d = S_ERR;
        end
`endif
      end
      S_GAP: begin
        if (abort_i)                state_d = S_DRAIN;
        else if (gap_inc == gap_q)  state_d = S_BURST;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
`ifdef USB_SCHED_WDOG_EN
      S_ERR: begin
        if (abort_i) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      gap_q      <= '0;
      num_q      <= '0;
      iss_q      <= '0;
      gap_cnt_q  <= '0;
      bursts_q   <= '0;
      words_q    <= '0;
      prod_rst_q <= 1'b0;
      prod_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Outputs are decoded from the next state so they are registered and
      // line up with the state they describe.
      prod_rst_q <= (state_d == S_PRST);
      prod_en_q  <= (state_d == S_BURST);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);

      if (state_q == S_IDLE && start_ok) begin
        len_q     <= burst_len_i;
        gap_q     <= gap_len_i;
        num_q     <= burst_num_i;
        iss_q     <= '0;
        gap_cnt_q <= '0;
        bursts_q  <= '0;
        words_q   <= '0;
      end else begin
        if (state_q == S_BURST && issue) begin
          iss_q <= last_issue ? '0 : iss_inc;
        end
        if (last_issue) bursts_q <= bursts_inc;
        gap_cnt_q <= (state_q == S_GAP) ? gap_inc : '0;
        if (busy_q && prod_wr_i && !(&words_q)) begin
          words_q <= words_q + WRD_W'(1);
        end
      end
    end
  end

`ifdef USB_SCHED_WDOG_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_BURST && stall) wd_q <= wd_inc;
      else                             wd_q <= '0;
      if (state_q == S_IDLE && start_ok) timeout_q <= 1'b0;
      else if (state_d == S_ERR)         timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  // TO_W only sizes the watchdog; without it the flag is a constant zero.
  assign timeout_o = |{TO_W{1'b0}};
`endif

  assign prod_rst_o    = prod_rst_q;
  assign prod_en_o     = prod_en_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign bursts_done_o = bursts_q;
  assign words_o       = words_q;

endmodule

// File: tb/tb_usb_prod_sched.sv
module tb_usb_prod_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] burst_len;
  logic [15:0] gap_len;
  logic [15:0] burst_num;
  logic        afull;
  logic        prod_wr;
  logic        prod_rst;
  logic        prod_en;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] bursts_done;
  logic [31:0] words;

  int n_checks;
  int n_fail;

  // Per-cycle expected {prod_rst, prod_en, busy, done, bursts_done}.
  logic [19:0] exp_q[$];
  logic        afull_arr[0:511];
  logic        abort_arr[0:511];
  int          exp_words;
  int          exp_bursts;

  usb_prod_sched #(
    .LEN_W(16), .GAP_W(16), .CNT_W(16), .WRD_W(32), .TO_W(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .abort_i(abort),
    .burst_len_i(burst_len),
    .gap_len_i(gap_len),
    .burst_num_i(burst_num),
    .fifo_almst_full_i(afull),
    .prod_wr_i(prod_wr),
    .prod_rst_o(prod_rst),
    .prod_en_o(prod_en),
    .busy_o(busy),
    .done_o(done),
    .timeout_o(timeout),
    .bursts_done_o(bursts_done),
    .words_o(words)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered producer: one write strobe the cycle after each issue.
  always @(posedge clk) begin
    if (!rst_n) prod_wr <= 1'b0;
    else        prod_wr <= prod_en & ~afull;
  end

  // Build the expected timeline from the run rules: PRST, then bursts of
  // len issues (stalled cycles do not count), gaps, then DRAIN, DONE, IDLE.
  task automatic build_model(input int len, input int gap, input int num,
                             input int abort_at);
    int t, iss, nb, got;
    bit stop;
    exp_q.delete();
    for (int k = 0; k < 512; k++) abort_arr[k] = 1'b0;
    t = 0; iss = 0; nb = 0; stop = 1'b0;
    exp_q.push_back({4'b1010, 16'd0});
    t = 1;
    while (!stop && t < 480) begin
      got = 0;
      while (!stop && got < len && t < 480) begin
        exp_q.push_back({4'b0110, 16'(nb)});
        if (!afull_arr[t]) begin
          got++;
          iss++;
          if (got == len) nb++;
          if (iss == abort_at) begin
            abort_arr[t] = 1'b1;
            stop = 1'b1;
          end
        end
        t++;
      end
      if (!stop && num != 0 && nb == num) stop = 1'b1;
      if (!stop) begin
        for (int g = 0; g < gap; g++) begin
          exp_q.push_back({4'b0010, 16'(nb)});
          t++;
        end
      end
    end
    exp_q.push_back({4'b0010, 16'(nb)});
    exp_q.push_back({4'b0011, 16'(nb)});
    exp_q.push_back({4'b0000, 16'(nb)});
    exp_words  = iss;
    exp_bursts = nb;
  endtask

  // Runs one train starting at a negedge; ends at the negedge of the first
  // IDLE cycle so a following run can start immediately.
  task automatic run_train(input string name, input int len, input int gap,
                           input int num, input int abort_at,
                           input int bp_pct, input bit preset,
                           input int restart_at);
    logic [19:0] obs;
    if (!preset) begin
      for (int k = 0; k < 512; k++)
        afull_arr[k] = ($urandom_range(99) < bp_pct);
    end
    build_model(len, gap, num, abort_at);
    burst_len = 16'(len);
    gap_len   = 16'(gap);
    burst_num = 16'(num);
    start     = 1'b1;
    afull     = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    start     = 1'b0;
    // Configuration is latched; later input changes must not matter.
    burst_len = 16'($urandom_range(1, 9));
    gap_len   = 16'($urandom_range(0, 9));
    burst_num = 16'($urandom_range(0, 9));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = {prod_rst, prod_en, busy, done, bursts_done};
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got rst/en/busy/done/bursts=%h required %h",
                 name, i, obs, exp_q[i]);
      end
      afull = afull_arr[i];
      abort = abort_arr[i];
      start = (i == restart_at);
      @(negedge clk);
    end
    afull = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    n_checks++;
    if (words !== 32'(exp_words)) begin
      n_fail++;
      $display("FAIL %s words: got %0d required %0d", name, words, exp_words);
    end
    n_checks++;
    if (bursts_done !== 16'(exp_bursts)) begin
      n_fail++;
      $display("FAIL %s bursts_done: got %0d required %0d", name, bursts_done,
               exp_bursts);
    end
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s timeout: got %b required 0", name, timeout);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({prod_rst, prod_en, busy, done, timeout} !== 5'b0 ||
        bursts_done !== 16'd0 || words !== 32'd0) begin
      n_fail++;
      $display("FAIL %s: got rst/en/busy/done/to=%b bursts=%0d words=%0d required all 0",
               name, {prod_rst, prod_en, busy, done, timeout}, bursts_done, words);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; afull = 1'b0;
    burst_len = 16'd0; gap_len = 16'd0; burst_num = 16'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_train();
    run_train("train_4_3_2", 4, 3, 2, 0, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 512; k++) afull_arr[k] = 1'b0;
    afull_arr[2] = 1'b1;
    afull_arr[3] = 1'b1;
    afull_arr[4] = 1'b1;
    run_train("backpressure", 5, 0, 1, 0, 0, 1'b1, -1);
  endtask

  task automatic test_free_run_abort();
    run_train("free_run_abort", 3, 1, 0, 4, 0, 1'b0, -1);
  endtask

  task automatic test_guards();
    burst_len = 16'd0; gap_len = 16'd2; burst_num = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (busy !== 1'b0 || prod_rst !== 1'b0) begin
        n_fail++;
        $display("FAIL guard_len0 cyc %0d: got busy=%b prod_rst=%b required 0 0",
                 i, busy, prod_rst);
      end
      @(negedge clk);
    end
    // A start pulse mid-run with a different configuration is ignored.
    run_train("guard_restart", 2, 1, 2, 0, 0, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    run_train("b2b_a", 3, 0, 2, 0, 20, 1'b0, -1);
    run_train("b2b_b", 2, 2, 1, 0, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_gap();
    burst_len = 16'd4; gap_len = 16'd5; burst_num = 16'd2;
    afull = 1'b0; abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // cycle 0 PRST, 1..4 burst, 5.. gap
    repeat (6) @(negedge clk);
    n_checks++;
    if (prod_en !== 1'b0 || busy !== 1'b1 || bursts_done !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_gap_pre: got en=%b busy=%b bursts=%0d required 0 1 1",
               prod_en, busy, bursts_done);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_gap");
    rst_n = 1'b1;
    run_train("after_reset", 3, 2, 2, 0, 20, 1'b0, -1);
  endtask

  task automatic test_random();
    int len, gap, num, ab;
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 6);
      gap = $urandom_range(0, 3);
      num = $urandom_range(0, 4);
      ab  = (num == 0) ? $urandom_range(1, 14) :
            (($urandom_range(3) == 0) ? $urandom_range(1, len * num) : 0);
      run_train($sformatf("random_%0d", r), len, gap, num, ab, 25, 1'b0, -1);
    end
  endtask

`ifdef USB_SCHED_WDOG_EN
  task automatic test_watchdog();
    burst_len = 16'd3; gap_len = 16'd0; burst_num = 16'd1;
    abort = 1'b0;
    afull = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // cycle 0 PRST, cycles 1..15 stalled, ERR from cycle 16
    for (int i = 0; i < 21; i++) begin
      n_checks++;
      if (prod_en !== (i >= 1 && i <= 15) || timeout !== (i >= 16) ||
          busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL watchdog cyc %0d: got en=%b to=%b busy=%b done=%b required %b %b 1 0",
                 i, prod_en, timeout, busy, done, (i >= 1 && i <= 15), (i >= 16));
      end
      abort = (i == 20);
      @(negedge clk);
    end
    abort = 1'b0;
    afull = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog_abort: got busy=%b to=%b done=%b required 0 1 0",
               busy, timeout, done);
    end
    run_train("after_watchdog", 2, 1, 2, 0, 0, 1'b0, -1);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_train();
    test_backpressure();
    test_free_run_abort();
    test_guards();
    test_back_to_back();
    test_reset_mid_gap();
    test_random();
`ifdef USB_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
